// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and default timing constants for cpu_run_ctrl
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_t;

    localparam logic [31:0] DEF_HALT_PC      = 32'h0000_0100;
    localparam int          DEF_DRAIN_CYCLES = 4;
    localparam int          DEF_CLEAR_CYCLES = 2;
    localparam logic [31:0] DEF_MAX_CYCLES   = 32'd1_000_000;

    // Width of the shared CLEAR/DRAIN phase down-counter.
    localparam int PHASE_W = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear and enable that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - sequences a CPU through clear, run, drain and done phases for the host
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_PC      = DEF_HALT_PC,
    parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int          CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter logic [31:0] MAX_CYCLES   = DEF_MAX_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        abort,
    input  logic [31:0] pc,
    output logic        cpu_start,
    output logic        cpu_clear,
    output logic        host_mem_sel,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    run_state_t         state;
    run_state_t         state_next;
    logic [PHASE_W-1:0] phase_cnt;
    logic [PHASE_W-1:0] phase_next;
    logic               launch;
    logic               watchdog;
    logic               count_en;

    assign count_en = (state == ST_RUN) || (state == ST_DRAIN);

    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        launch     = 1'b0;
        watchdog   = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state_next = ST_CLEAR;
                        phase_next = PHASE_W'(CLEAR_CYCLES - 1);
                        launch     = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (phase_cnt == '0) begin
                        state_next = ST_RUN;
                    end else begin
                        phase_next = phase_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    // Halt is checked first so a halt on the watchdog cycle still drains.
                    if (pc == HALT_PC) begin
                        state_next = ST_DRAIN;
                        phase_next = PHASE_W'(DRAIN_CYCLES - 1);
                    end else if (cycle_count >= (MAX_CYCLES - 32'd1)) begin
                        state_next = ST_DONE;
                        watchdog   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (phase_cnt == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        phase_next = phase_cnt - 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            cpu_start    <= 1'b0;
            cpu_clear    <= 1'b0;
            host_mem_sel <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            phase_cnt    <= phase_next;
            cpu_start    <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            cpu_clear    <= (state_next == ST_CLEAR);
            host_mem_sel <= (state_next == ST_IDLE) || (state_next == ST_DONE);
            busy         <= (state_next == ST_CLEAR) || (state_next == ST_RUN) ||
                            (state_next == ST_DRAIN);
            done         <= (state_next == ST_DONE);
            if (launch) begin
                timeout <= 1'b0;
            end else if (watchdog) begin
                timeout <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH(32)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .en    (count_en),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl (default and short-watchdog builds)
module tb_cpu_run_ctrl;

    logic        clk;
    logic        reset;
    logic        go;
    logic        abort;
    logic [31:0] pc;

    logic        a_start, a_clear, a_hms, a_busy, a_done, a_timeout;
    logic [31:0] a_count;
    logic        w_start, w_clear, w_hms, w_busy, w_done, w_timeout;
    logic [31:0] w_count;

    logic [5:0]  a_flags;
    logic [5:0]  w_flags;

    int n_cmp;
    int n_err;

    // {cpu_start, cpu_clear, host_mem_sel, busy, done, timeout}
    localparam logic [5:0] F_IDLE    = 6'b001000;
    localparam logic [5:0] F_CLEAR   = 6'b010100;
    localparam logic [5:0] F_RUN     = 6'b100100;
    localparam logic [5:0] F_DONE    = 6'b001010;
    localparam logic [5:0] F_DONE_TO = 6'b001011;

    assign a_flags = {a_start, a_clear, a_hms, a_busy, a_done, a_timeout};
    assign w_flags = {w_start, w_clear, w_hms, w_busy, w_done, w_timeout};

    cpu_run_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .abort        (abort),
        .pc           (pc),
        .cpu_start    (a_start),
        .cpu_clear    (a_clear),
        .host_mem_sel (a_hms),
        .busy         (a_busy),
        .done         (a_done),
        .timeout      (a_timeout),
        .cycle_count  (a_count)
    );

    cpu_run_ctrl #(
        .MAX_CYCLES(32'd16)
    ) u_dut_wd (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .abort        (abort),
        .pc           (pc),
        .cpu_start    (w_start),
        .cpu_clear    (w_clear),
        .host_mem_sel (w_hms),
        .busy         (w_busy),
        .done         (w_done),
        .timeout      (w_timeout),
        .cycle_count  (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        go    = 1'b0;
        abort = 1'b0;
        pc    = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pulses go and advances to the first RUN cycle (edge k+2).
    task automatic start_to_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go    = 1'b0;
        abort = 1'b0;
        pc    = 32'h0;
        #3;
        n_cmp++;
        if (a_flags !== F_IDLE) begin
            $display("FAIL reset_flags: got %b expected %b", a_flags, F_IDLE);
            n_err++;
        end
        n_cmp++;
        if (a_count !== 32'd0) begin
            $display("FAIL reset_count: got %0d expected 0", a_count);
            n_err++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_go_latency();
        go = 1'b1;
        tick();
        go = 1'b0;
        n_cmp++;
        if (a_flags !== F_CLEAR) begin
            $display("FAIL latency_cycle0: got %b expected %b", a_flags, F_CLEAR);
            n_err++;
        end
        tick();
        n_cmp++;
        if (a_flags !== F_CLEAR) begin
            $display("FAIL latency_cycle1: got %b expected %b", a_flags, F_CLEAR);
            n_err++;
        end
        tick();
        n_cmp++;
        if (a_flags !== F_RUN) begin
            $display("FAIL latency_cycle2: got %b expected %b", a_flags, F_RUN);
            n_err++;
        end
    endtask

    // Continues from the first RUN cycle left by test_go_latency.
    task automatic test_halt_drain();
        pc = 32'h0;
        for (int i = 0; i < 49; i++) tick();
        n_cmp++;
        if (a_count !== 32'd49 || a_flags !== F_RUN) begin
            $display("FAIL run_count49: got %0d/%b expected 49/%b", a_count, a_flags, F_RUN);
            n_err++;
        end
        pc = 32'h0000_0100;
        tick();
        pc = 32'h0;
        n_cmp++;
        if (a_flags !== F_RUN || a_count !== 32'd50) begin
            $display("FAIL drain_entry: got %b/%0d expected %b/50", a_flags, a_count, F_RUN);
            n_err++;
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (a_flags !== F_RUN || a_count !== 32'd53) begin
            $display("FAIL drain_last: got %b/%0d expected %b/53", a_flags, a_count, F_RUN);
            n_err++;
        end
        tick();
        n_cmp++;
        if (a_flags !== F_DONE || a_count !== 32'd54) begin
            $display("FAIL halt_done: got %b/%0d expected %b/54", a_flags, a_count, F_DONE);
            n_err++;
        end
        tick();
        n_cmp++;
        if (a_flags !== F_DONE || a_count !== 32'd54) begin
            $display("FAIL done_hold: got %b/%0d expected %b/54", a_flags, a_count, F_DONE);
            n_err++;
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        start_to_run();
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (w_flags !== F_RUN || w_count !== 32'd15) begin
            $display("FAIL wd_before: got %b/%0d expected %b/15", w_flags, w_count, F_RUN);
            n_err++;
        end
        tick();
        n_cmp++;
        if (w_flags !== F_DONE_TO || w_count !== 32'd16) begin
            $display("FAIL wd_done: got %b/%0d expected %b/16", w_flags, w_count, F_DONE_TO);
            n_err++;
        end
        tick();
        n_cmp++;
        if (w_flags !== F_DONE_TO || w_count !== 32'd16) begin
            $display("FAIL wd_hold: got %b/%0d expected %b/16", w_flags, w_count, F_DONE_TO);
            n_err++;
        end
    endtask

    // Continues from the timed-out DONE left by test_watchdog.
    task automatic test_restart_halt_wins();
        go = 1'b1;
        tick();
        go = 1'b0;
        n_cmp++;
        if (w_flags !== F_CLEAR || w_count !== 32'd0) begin
            $display("FAIL restart_clear: got %b/%0d expected %b/0", w_flags, w_count, F_CLEAR);
            n_err++;
        end
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        pc = 32'h0000_0100;
        tick();
        pc = 32'h0;
        n_cmp++;
        if (w_flags !== F_RUN || w_count !== 32'd16) begin
            $display("FAIL halt_wins: got %b/%0d expected %b/16", w_flags, w_count, F_RUN);
            n_err++;
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (w_flags !== F_DONE || w_count !== 32'd20) begin
            $display("FAIL halt_wins_done: got %b/%0d expected %b/20", w_flags, w_count, F_DONE);
            n_err++;
        end
    endtask

    task automatic test_abort_go();
        apply_reset();
        start_to_run();
        for (int i = 0; i < 5; i++) tick();
        abort = 1'b1;
        go    = 1'b1;
        tick();
        abort = 1'b0;
        go    = 1'b0;
        n_cmp++;
        if (a_flags !== F_IDLE) begin
            $display("FAIL abort_go: got %b expected %b", a_flags, F_IDLE);
            n_err++;
        end
        tick();
        n_cmp++;
        if (a_flags !== F_IDLE) begin
            $display("FAIL abort_stay_idle: got %b expected %b", a_flags, F_IDLE);
            n_err++;
        end
    endtask

    task automatic test_go_ignored_in_run();
        apply_reset();
        start_to_run();
        go = 1'b1;
        tick();
        tick();
        go = 1'b0;
        n_cmp++;
        if (a_flags !== F_RUN || a_count !== 32'd2) begin
            $display("FAIL go_in_run: got %b/%0d expected %b/2", a_flags, a_count, F_RUN);
            n_err++;
        end
    endtask

    task automatic test_async_reset_drain();
        apply_reset();
        start_to_run();
        pc = 32'h0000_0100;
        tick();
        pc = 32'h0;
        tick();
        n_cmp++;
        if (a_flags !== F_RUN || a_count !== 32'd2) begin
            $display("FAIL pre_reset_drain: got %b/%0d expected %b/2", a_flags, a_count, F_RUN);
            n_err++;
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (a_flags !== F_IDLE || a_count !== 32'd0) begin
            $display("FAIL async_reset: got %b/%0d expected %b/0", a_flags, a_count, F_IDLE);
            n_err++;
        end
        #1;
        reset = 1'b0;
        go    = 1'b1;
        tick();
        go = 1'b0;
        n_cmp++;
        if (a_flags !== F_CLEAR) begin
            $display("FAIL first_go_after_reset: got %b expected %b", a_flags, F_CLEAR);
            n_err++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_go_latency();
        test_halt_drain();
        test_watchdog();
        test_restart_halt_wins();
        test_abort_go();
        test_go_ignored_in_run();
        test_async_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
